// File: rtl/spw_tx_write_arbiter.sv
// Round-robin, packet-atomic arbiter for the SpaceWire TX FIFO write port.
// Each character is issued as a one-cycle fifo_we pulse followed by a forced low gap.
module spw_tx_write_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1,
    parameter int GAP   = 3
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic [N_REQ-1:0]   req,
    input  logic [9*N_REQ-1:0] data_in,
    output logic [N_REQ-1:0]   ack,
    output logic [ID_W-1:0]    grant_id,
    output logic               busy,
    output logic [8:0]         fifo_data,
    output logic               fifo_we,
    input  logic               fifo_full
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [ID_W-1:0] LAST_INIT = ID_W'(N_REQ - 1);

    logic [1:0]       r_state;
    logic [ID_W-1:0]  r_last;
    logic [ID_W-1:0]  r_grant;
    logic             r_busy;
    logic             r_we;
    logic             r_eop;
    logic [N_REQ-1:0] r_ack;
    logic [8:0]       r_data;
    logic [3:0]       r_cnt;

    logic [8:0]       w_chars [N_REQ];
    logic [8:0]       w_char;
    logic             w_is_eop;
    logic             w_found;
    logic [ID_W-1:0]  w_winner;
    logic [ID_W-1:0]  w_cand;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_chars[g] = data_in[9*g +: 9];
    end

    assign w_char   = w_chars[r_grant];
    // Only EOP (0x100) and EEP (0x101) close a packet; other control codes pass as data.
    assign w_is_eop = w_char[8] && (w_char[7:1] == 7'd0);

    // Rotating priority: scan starts one past the last requester that finished a packet.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_cand = ID_W'((int'(r_last) + i) % N_REQ);
            if (!w_found && req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_last  <= LAST_INIT;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_we    <= 1'b0;
            r_eop   <= 1'b0;
            r_ack   <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_winner;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // The lock is held here even if the owner drops req mid-packet.
                    if (req[r_grant] && !fifo_full) begin
                        r_data  <= w_char;
                        r_we    <= 1'b1;
                        r_ack   <= N_REQ'(1) << r_grant;
                        r_eop   <= w_is_eop;
                        r_cnt   <= 4'(GAP);
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    r_we  <= 1'b0;
                    r_ack <= '0;
                    if (r_cnt == 4'd0) begin
                        if (r_eop) begin
                            r_last  <= r_grant;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack       = r_ack;
    assign grant_id  = r_grant;
    assign busy      = r_busy;
    assign fifo_data = r_data;
    assign fifo_we   = r_we;
endmodule

// File: tb/tb_spw_tx_write_arbiter.sv
// Scoreboarded bench for spw_tx_write_arbiter with three requesters and GAP=3.
module tb_spw_tx_write_arbiter;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [9*N-1:0] data_in = '0;
    logic [N-1:0] ack;
    logic [1:0]   grant_id;
    logic         busy;
    logic [8:0]   fifo_data;
    logic         fifo_we;
    logic         fifo_full = 1'b0;

    spw_tx_write_arbiter #(.N_REQ(N), .ID_W(2), .GAP(3)) dut (
        .CLOCK(clk), .RESET(rst), .req(req), .data_in(data_in), .ack(ack),
        .grant_id(grant_id), .busy(busy), .fifo_data(fifo_data),
        .fifo_we(fifo_we), .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int fails = 0;
    int pump_start = 0;

    typedef struct packed { logic [1:0] id; logic [8:0] d; } exp_t;
    exp_t sb[$];
    int   pulse_t[$];

    logic [8:0] ach [N][8];
    int acnt [N];
    int aptr [N];

    task automatic clear_agents();
        for (int i = 0; i < N; i++) begin
            acnt[i] = 0;
            aptr[i] = 0;
        end
        sb.delete();
        pulse_t.delete();
    endtask

    task automatic add(input int id, input logic [8:0] c);
        ach[id][acnt[id]] = c;
        acnt[id]++;
    endtask

    task automatic expect_w(input int id, input logic [8:0] c);
        exp_t e;
        e.id = id[1:0];
        e.d  = c;
        sb.push_back(e);
    endtask

    task automatic wait_we(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < max_cyc && !seen; c++) begin
            @(negedge clk);
            seen = fifo_we;
        end
    endtask

    // Drives queued characters per requester and checks every write against the scoreboard.
    task automatic pump(input int max_cyc);
        exp_t e;
        bit done;
        done = 1'b0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            @(negedge clk);
            if (c == 0) pump_start = cyc;
            vectors++;
            if (fifo_we) begin
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL sb_extra_write: got id=%0d data=%h, expected no write", grant_id, fifo_data);
                end else begin
                    e = sb.pop_front();
                    if (fifo_data !== e.d || grant_id !== e.id || ack !== (3'b001 << e.id)) begin
                        fails++;
                        $display("FAIL sb_write: got id=%0d data=%h ack=%b, expected id=%0d data=%h", grant_id, fifo_data, ack, e.id, e.d);
                    end
                end
                pulse_t.push_back(cyc);
            end else if (ack !== '0) begin
                fails++;
                $display("FAIL ack_without_we: got ack=%b, expected 000", ack);
            end
            for (int i = 0; i < N; i++)
                if (ack[i] && aptr[i] < acnt[i]) aptr[i]++;
            done = (sb.size() == 0) && !busy;
            for (int i = 0; i < N; i++) begin
                req[i] = (aptr[i] < acnt[i]);
                if (req[i]) begin
                    data_in[9*i +: 9] = ach[i][aptr[i]];
                    done = 1'b0;
                end
            end
        end
        vectors++;
        if (!done) begin
            fails++;
            $display("FAIL pump_timeout: got %0d writes outstanding busy=%b, expected drained", sb.size(), busy);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; req = '0; fifo_full = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors += 5;
        if (ack !== 3'b000) begin fails++; $display("FAIL reset_ack: got %b, expected 000", ack); end
        if (fifo_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b, expected 0", fifo_we); end
        if (fifo_data !== 9'h000) begin fails++; $display("FAIL reset_data: got %h, expected 000", fifo_data); end
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant: got %0d, expected 0", grant_id); end
        rst = 1'b0;
    endtask

    task automatic test_single_packet();
        clear_agents();
        add(0, 9'h041); add(0, 9'h042); add(0, 9'h100);
        expect_w(0, 9'h041); expect_w(0, 9'h042); expect_w(0, 9'h100);
        pump(100);
        vectors++;
        if (pulse_t.size() != 3) begin
            fails++; $display("FAIL single_count: got %0d pulses, expected 3", pulse_t.size());
        end else begin
            vectors += 3;
            if (pulse_t[0] - pump_start != 2) begin fails++; $display("FAIL single_latency: got %0d, expected 2", pulse_t[0] - pump_start); end
            if (pulse_t[1] - pulse_t[0] != 5 || pulse_t[2] - pulse_t[1] != 5) begin
                fails++; $display("FAIL single_spacing: got %0d/%0d, expected 5/5", pulse_t[1] - pulse_t[0], pulse_t[2] - pulse_t[1]);
            end
            if (cyc - pulse_t[2] != 4) begin fails++; $display("FAIL single_busy_drop: got %0d, expected 4", cyc - pulse_t[2]); end
        end
    endtask

    task automatic test_round_robin();
        reset_dut();
        clear_agents();
        add(0, 9'h0A0); add(0, 9'h100); add(0, 9'h0A1); add(0, 9'h100);
        add(1, 9'h0B0); add(1, 9'h100);
        add(2, 9'h0C0); add(2, 9'h100);
        expect_w(0, 9'h0A0); expect_w(0, 9'h100);
        expect_w(1, 9'h0B0); expect_w(1, 9'h100);
        expect_w(2, 9'h0C0); expect_w(2, 9'h100);
        expect_w(0, 9'h0A1); expect_w(0, 9'h100);
        pump(300);
        vectors++;
        if (pulse_t.size() != 8 || pulse_t[2] - pulse_t[1] != 6) begin
            fails++; $display("FAIL rr_boundary: got %0d pulses, expected 8 with 6-cycle packet boundary", pulse_t.size());
        end
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        @(negedge clk);
        req = 3'b010; data_in[17:9] = 9'h155; fifo_full = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (fifo_we !== 1'b0 || ack !== 3'b000) bad++;
        end
        vectors += 2;
        if (bad != 0) begin fails++; $display("FAIL bp_hold: got %0d cycles with write, expected 0", bad); end
        if (grant_id !== 2'd1 || busy !== 1'b1) begin fails++; $display("FAIL bp_grant: got id=%0d busy=%b, expected 1/1", grant_id, busy); end
        fifo_full = 1'b0;
        @(negedge clk);
        vectors++;
        if (fifo_we !== 1'b1 || fifo_data !== 9'h155 || ack !== 3'b010) begin
            fails++; $display("FAIL bp_release: got we=%b data=%h ack=%b, expected 1/155/010", fifo_we, fifo_data, ack);
        end
        clear_agents();
        add(1, 9'h100);
        expect_w(1, 9'h100);
        pump(50);
    endtask

    task automatic test_lock();
        bit seen;
        int bad;
        @(negedge clk);
        req = 3'b011; data_in[8:0] = 9'h011; data_in[17:9] = 9'h022;
        wait_we(10, seen);
        vectors++;
        if (!seen || fifo_data !== 9'h011 || grant_id !== 2'd0) begin
            fails++; $display("FAIL lock_first: got seen=%b data=%h id=%0d, expected 1/011/0", seen, fifo_data, grant_id);
        end
        req[0] = 1'b0;
        bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (fifo_we !== 1'b0 || grant_id !== 2'd0 || busy !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin fails++; $display("FAIL lock_hold: got %0d bad cycles, expected 0", bad); end
        req[0] = 1'b1; data_in[8:0] = 9'h101;
        wait_we(10, seen);
        vectors++;
        if (!seen || fifo_data !== 9'h101 || ack !== 3'b001) begin
            fails++; $display("FAIL lock_eep: got seen=%b data=%h ack=%b, expected 1/101/001", seen, fifo_data, ack);
        end
        req[0] = 1'b0;
        wait_we(20, seen);
        vectors++;
        if (!seen || fifo_data !== 9'h022 || grant_id !== 2'd1 || ack !== 3'b010) begin
            fails++; $display("FAIL lock_handover: got seen=%b data=%h id=%0d, expected 1/022/1", seen, fifo_data, grant_id);
        end
        data_in[17:9] = 9'h100;
        wait_we(20, seen);
        req[1] = 1'b0;
        repeat (6) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin fails++; $display("FAIL lock_release: got busy=%b, expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        req = 3'b010; data_in[17:9] = 9'h066;
        wait_we(20, seen);
        vectors++;
        if (!seen || grant_id !== 2'd1) begin fails++; $display("FAIL rstmid_start: got seen=%b id=%0d, expected 1/1", seen, grant_id); end
        @(negedge clk);
        rst = 1'b1; req = '0;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (fifo_we !== 1'b0 || busy !== 1'b0 || ack !== 3'b000 || grant_id !== 2'd0) begin
            fails++; $display("FAIL rstmid_state: got we=%b busy=%b ack=%b id=%0d, expected 0/0/000/0", fifo_we, busy, ack, grant_id);
        end
        clear_agents();
        add(0, 9'h100); add(1, 9'h100); add(2, 9'h100);
        expect_w(0, 9'h100); expect_w(1, 9'h100); expect_w(2, 9'h100);
        pump(200);
    endtask

    task automatic test_ctrl_passthru();
        clear_agents();
        add(0, 9'h041); add(0, 9'h1FF); add(0, 9'h102); add(0, 9'h100);
        add(1, 9'h0AA); add(1, 9'h100);
        expect_w(0, 9'h041); expect_w(0, 9'h1FF); expect_w(0, 9'h102); expect_w(0, 9'h100);
        expect_w(1, 9'h0AA); expect_w(1, 9'h100);
        pump(300);
        vectors++;
        if (pulse_t.size() != 6 || pulse_t[1] - pulse_t[0] != 5 || pulse_t[2] - pulse_t[1] != 5 || pulse_t[3] - pulse_t[2] != 5) begin
            fails++; $display("FAIL ctrl_spacing: got %0d pulses, expected 6 with 5-cycle in-packet spacing", pulse_t.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_lock();
        test_reset_mid();
        test_ctrl_passthru();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish within 20000 cycles");
        $fatal(1);
    end
endmodule
